exec_sequencer: RTL and testbench

- Execution controller that sequences the processing unit through a single-cycle clock-enable pulse (cpu_en) in place of driving it from the debounced button clock.
- Supports single-step mode and free-run mode.
- Stalls on an IN instruction until the user confirms the switch value.
- Freezes permanently on HLT.
- Sits at CPU top between Debounce, the control unit (HLT, in_req) and the processing unit (enable, input latch).

---
 rtl/cpu_ctrl_pkg.sv | 14 +
 rtl/edge_detect.sv | 23 ++
 rtl/exec_sequencer.sv | 153 +++++++++++++++
 tb/tb_exec_sequencer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the execution sequencer: FSM encoding and parameter limits.
package cpu_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_WAIT_IN = 2'd2,
        ST_HALT    = 2'd3
    } state_e;

    // Smallest free-run divider that still leaves room for the post-pulse settle cycle.
    localparam int unsigned RUN_DIV_MIN = 2;

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector for the debounced step button.
// rise_o is combinational: it is high during the cycle in which btn_i first reads 1.
module edge_detect (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic rise_o
);

    logic btn_prev_q;

    // Previous button level
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            btn_prev_q <= 1'b0;
        end else begin
            btn_prev_q <= btn_i;
        end
    end

    assign rise_o = btn_i & ~btn_prev_q;

endmodule

// File: rtl/exec_sequencer.sv
// Execution controller: turns button presses / free-run ticks into one-cycle
// cpu_en pulses, stalls on IN until the user confirms, and freezes on HLT.
module exec_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned RUN_DIV = 4,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             step_btn,
    input  logic             run_mode,
    input  logic             hlt,
    input  logic             in_req,
    output logic             cpu_en,
    output logic             in_ack,
    output logic             waiting_in,
    output logic             halted,
    output logic [CNT_W-1:0] instr_count
);

    localparam int unsigned DIV_W = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

    if (RUN_DIV < RUN_DIV_MIN) begin : g_run_div_check
        $error("exec_sequencer: RUN_DIV must be at least %0d", RUN_DIV_MIN);
    end

    state_e             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic               pend_q, pend_d;
    logic               settle_q;
    logic               cpu_en_q, cpu_en_d;
    logic               in_ack_q, in_ack_d;
    logic               waiting_in_q, waiting_in_d;
    logic               halted_q, halted_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               btn_rise;

    edge_detect u_edge_detect (
        .clk_i  (CLK),
        .rst_i  (Reset),
        .btn_i  (step_btn),
        .rise_o (btn_rise)
    );

    // Next state, divider, pending press and registered-output next values
    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        // A press landing in the cycle that consumes pend is dropped (pend is one-deep)
        pend_d   = pend_q | btn_rise;
        cpu_en_d = 1'b0;
        in_ack_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                div_d = '0;
                if (!settle_q) begin
                    if (hlt) begin
                        state_d = ST_HALT;
                    end else if (pend_q) begin
                        pend_d = 1'b0;
                        if (run_mode) begin
                            state_d = ST_RUN;
                        end else if (in_req) begin
                            state_d = ST_WAIT_IN;
                        end else begin
                            cpu_en_d = 1'b1;
                        end
                    end
                end
            end

            ST_RUN: begin
                pend_d = 1'b0;
                if (!run_mode) begin
                    state_d = ST_IDLE;
                    div_d   = '0;
                end else if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (!settle_q) begin
                        if (hlt) begin
                            state_d = ST_HALT;
                        end else if (in_req) begin
                            state_d = ST_WAIT_IN;
                        end else begin
                            cpu_en_d = 1'b1;
                        end
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end

            ST_WAIT_IN: begin
                div_d = '0;
                if (!settle_q && pend_q) begin
                    pend_d   = 1'b0;
                    cpu_en_d = 1'b1;
                    in_ack_d = 1'b1;
                    state_d  = run_mode ? ST_RUN : ST_IDLE;
                end
            end

            ST_HALT: begin
                div_d  = '0;
                pend_d = 1'b0;
            end

            default: begin
                state_d = ST_IDLE;
                div_d   = '0;
            end
        endcase

        waiting_in_d = (state_d == ST_WAIT_IN);
        halted_d     = (state_d == ST_HALT);
        count_d      = (cpu_en_q && (count_q != {CNT_W{1'b1}})) ? count_q + CNT_W'(1) : count_q;
    end

    // State, divider and registered outputs
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q      <= ST_IDLE;
            div_q        <= '0;
            pend_q       <= 1'b0;
            settle_q     <= 1'b0;
            cpu_en_q     <= 1'b0;
            in_ack_q     <= 1'b0;
            waiting_in_q <= 1'b0;
            halted_q     <= 1'b0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            pend_q       <= pend_d;
            settle_q     <= cpu_en_q;
            cpu_en_q     <= cpu_en_d;
            in_ack_q     <= in_ack_d;
            waiting_in_q <= waiting_in_d;
            halted_q     <= halted_d;
            count_q      <= count_d;
        end
    end

    assign cpu_en      = cpu_en_q;
    assign in_ack      = in_ack_q;
    assign waiting_in  = waiting_in_q;
    assign halted      = halted_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// Scoreboard bench for exec_sequencer: stimulus queues expected pulses (cycle, in_ack),
// a negedge monitor pops and compares whenever cpu_en is seen.
module tb_exec_sequencer;

    localparam int unsigned CNT_W = 4;

    logic             CLK;
    logic             Reset;
    logic             step_btn;
    logic             run_mode;
    logic             hlt;
    logic             in_req;
    logic             cpu_en;
    logic             in_ack;
    logic             waiting_in;
    logic             halted;
    logic [CNT_W-1:0] instr_count;

    typedef struct {
        int cyc;
        bit ack;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    exec_sequencer #(.RUN_DIV(4), .CNT_W(CNT_W)) dut (
        .CLK         (CLK),
        .Reset       (Reset),
        .step_btn    (step_btn),
        .run_mode    (run_mode),
        .hlt         (hlt),
        .in_req      (in_req),
        .cpu_en      (cpu_en),
        .in_ack      (in_ack),
        .waiting_in  (waiting_in),
        .halted      (halted),
        .instr_count (instr_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int want);
        n_chk++;
        if (act == want) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, want, cyc);
    endtask

    task automatic exp_pulse(input int t, input bit ack);
        exp_t e;
        e.cyc = t;
        e.ack = ack;
        exp_q.push_back(e);
    endtask

    task automatic go_to(input int t);
        while (cyc < t) @(negedge CLK);
    endtask

    // Rising edge on step_btn during the current cycle; returns that cycle number
    task automatic press(output int c);
        c = cyc;
        step_btn = 1'b1;
        @(negedge CLK);
        step_btn = 1'b0;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        exp_q.delete();
        repeat (2) @(negedge CLK);
        Reset = 1'b0;
    endtask

    // Monitor: every cpu_en cycle must match the head of the expected queue
    always @(negedge CLK) begin
        if (!Reset) begin
            if (cpu_en) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_pulse: cpu_en=1 at cycle %0d, none expected", cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("pulse_cycle", cyc, mon_e.cyc);
                    chk("pulse_in_ack", int'(in_ack), int'(mon_e.ack));
                end
            end else begin
                if (in_ack) begin
                    n_chk++;
                    $display("FAIL stray_in_ack: in_ack=1 without cpu_en at cycle %0d", cyc);
                end
                if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
                    mon_e = exp_q.pop_front();
                    n_chk++;
                    $display("FAIL missing_pulse: no cpu_en, expected one at cycle %0d", mon_e.cyc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected end well before", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c, c2, c3, r;
        Reset    = 1'b1;
        step_btn = 1'b0;
        run_mode = 1'b0;
        hlt      = 1'b0;
        in_req   = 1'b0;
        repeat (3) @(negedge CLK);
        Reset = 1'b0;
        @(negedge CLK);
        chk("rst_cpu_en",     int'(cpu_en), 0);
        chk("rst_in_ack",     int'(in_ack), 0);
        chk("rst_waiting_in", int'(waiting_in), 0);
        chk("rst_halted",     int'(halted), 0);
        chk("rst_count",      int'(instr_count), 0);

        // Single step: pulse two cycles after the edge, then two more presses
        do_reset();
        @(negedge CLK);
        press(c);
        exp_pulse(c + 2, 1'b0);
        go_to(c + 6);
        chk("single_count1", int'(instr_count), 1);
        for (int i = 0; i < 2; i++) begin
            press(c);
            exp_pulse(c + 2, 1'b0);
            go_to(c + 5);
        end
        go_to(cyc + 2);
        chk("single_count3", int'(instr_count), 3);

        // Presses around the settle window
        do_reset();
        @(negedge CLK);
        press(c);
        exp_pulse(c + 2, 1'b0);
        go_to(c + 2);
        press(c2);                       // edge in the pulse cycle, pend held over settle
        exp_pulse(c2 + 3, 1'b0);
        go_to(c2 + 4);
        press(c3);                       // edge in the settle cycle right after the pulse
        exp_pulse(c3 + 2, 1'b0);
        go_to(c3 + 2);
        press(r);                        // edge in pulse cycle ...
        exp_pulse(r + 3, 1'b0);
        go_to(r + 2);
        press(c);                        // ... and again in the cycle that consumes pend: dropped
        go_to(r + 10);
        chk("settle_count", int'(instr_count), 4);

        // Free run: pulses every 4 cycles, stop when run_mode drops
        do_reset();
        @(negedge CLK);
        run_mode = 1'b1;
        press(c);
        for (int k = 0; k < 4; k++) exp_pulse(c + 6 + 4 * k, 1'b0);
        go_to(c + 19);
        run_mode = 1'b0;
        go_to(c + 30);
        chk("run_count", int'(instr_count), 4);
        chk("run_waiting_in", int'(waiting_in), 0);

        // IN stall in free run, confirm with a press, then resume
        do_reset();
        @(negedge CLK);
        run_mode = 1'b1;
        press(c);
        exp_pulse(c + 6, 1'b0);
        exp_pulse(c + 10, 1'b0);
        go_to(c + 11);
        in_req = 1'b1;
        go_to(c + 15);
        chk("in_waiting", int'(waiting_in), 1);
        chk("in_not_halted", int'(halted), 0);
        go_to(c + 16);
        press(c2);
        exp_pulse(c + 18, 1'b1);
        exp_pulse(c + 22, 1'b0);
        exp_pulse(c + 26, 1'b0);
        go_to(c + 18);
        in_req = 1'b0;
        go_to(c + 19);
        chk("in_waiting_clr", int'(waiting_in), 0);
        go_to(c + 27);
        run_mode = 1'b0;
        go_to(c + 33);
        chk("in_count", int'(instr_count), 5);

        // HALT beats IN; presses and mode changes are ignored; Reset exits
        do_reset();
        @(negedge CLK);
        press(c);
        exp_pulse(c + 2, 1'b0);
        go_to(c + 5);
        hlt    = 1'b1;
        in_req = 1'b1;
        press(c2);
        go_to(c2 + 2);
        chk("halt_halted", int'(halted), 1);
        chk("halt_waiting_in", int'(waiting_in), 0);
        chk("halt_in_ack", int'(in_ack), 0);
        run_mode = 1'b1;
        press(c3);
        go_to(c3 + 3);
        run_mode = 1'b0;
        press(c3);
        go_to(c3 + 8);
        chk("halt_sticky", int'(halted), 1);
        chk("halt_count", int'(instr_count), 1);
        hlt    = 1'b0;
        in_req = 1'b0;
        do_reset();
        @(negedge CLK);
        chk("halt_rst_halted", int'(halted), 0);
        chk("halt_rst_count", int'(instr_count), 0);

        // Counter saturation, then async reset in the middle of a pulse
        do_reset();
        @(negedge CLK);
        run_mode = 1'b1;
        press(c);
        for (int k = 0; k < 21; k++) exp_pulse(c + 6 + 4 * k, 1'b0);
        go_to(c + 84);
        chk("sat_count", int'(instr_count), 15);
        go_to(c + 86);
        #2;
        chk("async_pre_cpu_en", int'(cpu_en), 1);
        Reset = 1'b1;
        #1;
        chk("async_cpu_en", int'(cpu_en), 0);
        chk("async_count", int'(instr_count), 0);
        exp_q.delete();
        run_mode = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        Reset = 1'b0;
        go_to(cyc + 5);

        while (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            n_chk++;
            $display("FAIL missing_pulse: no cpu_en, expected one at cycle %0d", mon_e.cyc);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
